// File: rtl/reaction_timer_datapath.sv
// Purpose: timing datapath for the reaction-timer FSM (random wait, fixed wait, ms reaction count, result latch).
// Latency: all outputs are registered; waits expire exactly len_ms*CYCLES_PER_MS cycles after the start rise.
// Backpressure: none; commands are levels and status outputs are levels held while the command stays high.
module reaction_timer_datapath #(
   parameter int          CYCLES_PER_MS = 100000,
   parameter int          RWAIT_MIN_MS  = 2000,
   parameter int          RAND_MASK     = 4095,
   parameter int          WAIT5_MS      = 5000,
   parameter int          TIME_LIMIT_MS = 9999,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        start_rwait,
   input  logic        start_wait5,
   input  logic        time_clr,
   input  logic        time_en,
   input  logic        rs_en,
   output logic        rwait_done,
   output logic        wait5_done,
   output logic        time_late,
   output logic [13:0] react_ms,
   output logic [13:0] result_ms,
   output logic        result_valid,
   output logic [13:0] rwait_len_ms
);

   localparam int          PW       = (CYCLES_PER_MS > 2) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [PW-1:0] PTERM  = PW'(CYCLES_PER_MS - 1);
   localparam logic [13:0] RMIN     = 14'(RWAIT_MIN_MS);
   localparam logic [13:0] RMASK    = 14'(RAND_MASK);
   localparam logic [13:0] W5LEN    = 14'(WAIT5_MS);
   localparam logic [13:0] LIMIT    = 14'(TIME_LIMIT_MS);
   localparam logic [15:0] TAPS     = 16'hB400;

   // Parameter ranges that would overflow the 14-bit ms arithmetic are rejected at elaboration.
   if (RWAIT_MIN_MS + RAND_MASK > 16383) begin : g_bad_rwait
      $error("RWAIT_MIN_MS + RAND_MASK exceeds 14-bit range");
   end
   if (TIME_LIMIT_MS > 16383 || WAIT5_MS > 16383) begin : g_bad_limit
      $error("TIME_LIMIT_MS or WAIT5_MS exceeds 14-bit range");
   end
   if (CYCLES_PER_MS < 2) begin : g_bad_cpm
      $error("CYCLES_PER_MS must be at least 2");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end

   logic [15:0]   lfsr;
   logic          rwait_q, wait5_q, rs_q;
   logic [PW-1:0] wpresc, rpresc;
   logic [13:0]   rwait_cnt, wait5_cnt;
   logic          rwait_arm, wait5_arm;

   logic        rwait_rise, wait5_rise, rs_rise, wtick, rtick;
   logic [13:0] rwait_load;

   assign rwait_rise = start_rwait & ~rwait_q;
   assign wait5_rise = start_wait5 & ~wait5_q;
   assign rs_rise    = rs_en & ~rs_q;
   assign wtick      = (wpresc == PTERM);
   assign rtick      = (rpresc == PTERM);
   // Random delay is sampled from the LFSR value present in the rise cycle.
   assign rwait_load = RMIN + (lfsr[13:0] & RMASK);

   // Free-running Galois LFSR and the rise-detect copies of the level commands.
   always_ff @(posedge clk) begin
      if (RESET) begin
         lfsr    <= LFSR_SEED;
         rwait_q <= 1'b0;
         wait5_q <= 1'b0;
         rs_q    <= 1'b0;
      end else begin
         lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
         rwait_q <= start_rwait;
         wait5_q <= start_wait5;
         rs_q    <= rs_en;
      end
   end

   // Shared wait prescaler; realigned on either start rise so expiry is cycle-exact.
   always_ff @(posedge clk) begin
      if (RESET || rwait_rise || wait5_rise || wtick) begin
         wpresc <= '0;
      end else begin
         wpresc <= wpresc + 1'b1;
      end
   end

   // Random wait: load on rise, count down on ms ticks, hold done until start_rwait drops.
   always_ff @(posedge clk) begin
      if (RESET) begin
         rwait_cnt    <= '0;
         rwait_arm    <= 1'b0;
         rwait_done   <= 1'b0;
         rwait_len_ms <= '0;
      end else if (!start_rwait) begin
         rwait_arm  <= 1'b0;
         rwait_done <= 1'b0;
      end else if (rwait_rise) begin
         rwait_len_ms <= rwait_load;
         rwait_cnt    <= rwait_load;
         rwait_arm    <= 1'b1;
         rwait_done   <= 1'b0;
      end else if (rwait_arm && wtick) begin
         if (rwait_cnt <= 14'd1) begin
            rwait_cnt  <= '0;
            rwait_arm  <= 1'b0;
            rwait_done <= 1'b1;
         end else begin
            rwait_cnt <= rwait_cnt - 14'd1;
         end
      end
   end

   // Fixed wait: same mechanism as the random wait with a constant length.
   always_ff @(posedge clk) begin
      if (RESET) begin
         wait5_cnt  <= '0;
         wait5_arm  <= 1'b0;
         wait5_done <= 1'b0;
      end else if (!start_wait5) begin
         wait5_arm  <= 1'b0;
         wait5_done <= 1'b0;
      end else if (wait5_rise) begin
         wait5_cnt  <= W5LEN;
         wait5_arm  <= 1'b1;
         wait5_done <= 1'b0;
      end else if (wait5_arm && wtick) begin
         if (wait5_cnt <= 14'd1) begin
            wait5_cnt  <= '0;
            wait5_arm  <= 1'b0;
            wait5_done <= 1'b1;
         end else begin
            wait5_cnt <= wait5_cnt - 14'd1;
         end
      end
   end

   // Reaction counter with its own prescaler; clear wins over enable, count saturates at the limit.
   always_ff @(posedge clk) begin
      if (RESET || time_clr) begin
         rpresc    <= '0;
         react_ms  <= '0;
         time_late <= 1'b0;
      end else begin
         time_late <= (react_ms >= LIMIT);
         if (time_en) begin
            if (rtick) begin
               rpresc <= '0;
               if (react_ms < LIMIT) begin
                  react_ms <= react_ms + 14'd1;
               end
            end else begin
               rpresc <= rpresc + 1'b1;
            end
         end
      end
   end

   // Result latch: capture on rs_en rise, valid follows rs_en level.
   always_ff @(posedge clk) begin
      if (RESET) begin
         result_ms    <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= rs_en;
         if (rs_rise) begin
            result_ms <= react_ms;
         end
      end
   end

endmodule

// File: tb/tb_reaction_timer_datapath.sv
// Directed bench for reaction_timer_datapath with small timing parameters.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// LFSR reference model runs alongside the DUT to predict random delays.
module tb_reaction_timer_datapath;

   logic        clk = 1'b0;
   logic        RESET;
   logic        start_rwait, start_wait5, time_clr, time_en, rs_en;
   logic        rwait_done, wait5_done, time_late, result_valid;
   logic [13:0] react_ms, result_ms, rwait_len_ms;

   int checks = 0;
   int errors = 0;
   logic [15:0] m_lfsr;
   logic [13:0] exp_len;

   reaction_timer_datapath #(
      .CYCLES_PER_MS(4), .RWAIT_MIN_MS(2), .RAND_MASK(3),
      .WAIT5_MS(5), .TIME_LIMIT_MS(10), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .RESET(RESET),
      .start_rwait(start_rwait), .start_wait5(start_wait5),
      .time_clr(time_clr), .time_en(time_en), .rs_en(rs_en),
      .rwait_done(rwait_done), .wait5_done(wait5_done), .time_late(time_late),
      .react_ms(react_ms), .result_ms(result_ms), .result_valid(result_valid),
      .rwait_len_ms(rwait_len_ms)
   );

   always #5 clk = ~clk;

   // Reference Galois LFSR, seed 0xACE1, taps 0xB400.
   always @(posedge clk) begin
      if (RESET) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count cycles after the rise edge until the selected done flag is high.
   task automatic wait_done(input bit sel5, input int exp_cycles, input string tag);
      int n = 0;
      while (((sel5 ? wait5_done : rwait_done) !== 1'b1) && n < 200) begin
         tick();
         n++;
      end
      chk(tag, n, exp_cycles);
   endtask

   initial begin
      RESET = 1'b1;
      start_rwait = 0; start_wait5 = 0; time_clr = 0; time_en = 0; rs_en = 0;

      // 1. reset with toggling inputs
      for (int i = 0; i < 3; i++) begin
         {start_rwait, start_wait5, time_clr, time_en, rs_en} = 5'($urandom_range(0, 31));
         tick();
         chk("rst_flags", {rwait_done, wait5_done, time_late, result_valid}, 0);
         chk("rst_react", react_ms, 0);
         chk("rst_result", result_ms, 0);
         chk("rst_rlen", rwait_len_ms, 0);
      end
      start_rwait = 0; start_wait5 = 0; time_clr = 0; time_en = 0; rs_en = 0;
      RESET = 1'b0;
      tick();

      // LFSR sequence observed through several short random-wait loads
      for (int i = 0; i < 6; i++) begin
         start_rwait = 1'b1;
         exp_len = 14'd2 + 14'(m_lfsr & 16'd3);
         tick();
         chk("lfsr_len", rwait_len_ms, exp_len);
         start_rwait = 1'b0;
         repeat ($urandom_range(1, 4)) tick();
      end

      // 2. full random wait
      start_rwait = 1'b1;
      exp_len = 14'd2 + 14'(m_lfsr & 16'd3);
      tick();
      chk("rw_len", rwait_len_ms, exp_len);
      chk("rw_range", (rwait_len_ms >= 2 && rwait_len_ms <= 5), 1);
      wait_done(1'b0, 4 * int'(exp_len), "rw_expiry");
      tick();
      chk("rw_hold", rwait_done, 1);
      start_rwait = 1'b0;
      tick();
      chk("rw_drop", rwait_done, 0);

      // 3. aborted random wait, then fresh load
      start_rwait = 1'b1;
      exp_len = 14'd2 + 14'(m_lfsr & 16'd3);
      repeat (3) tick();
      chk("abort_len", rwait_len_ms, exp_len);
      start_rwait = 1'b0;
      begin
         int seen = 0;
         repeat (40) begin
            tick();
            if (rwait_done) seen++;
         end
         chk("abort_never", seen, 0);
      end
      start_rwait = 1'b1;
      exp_len = 14'd2 + 14'(m_lfsr & 16'd3);
      tick();
      chk("reload_len", rwait_len_ms, exp_len);
      wait_done(1'b0, 4 * int'(exp_len), "reload_expiry");
      start_rwait = 1'b0;
      tick();

      // 4. reaction count and result latch
      time_clr = 1'b1;
      tick();
      time_clr = 1'b0;
      time_en = 1'b1;
      repeat (28) tick();
      time_en = 1'b0;
      rs_en = 1'b1;
      chk("react7", react_ms, 7);
      chk("late0", time_late, 0);
      tick();
      chk("result7", result_ms, 7);
      chk("valid1", result_valid, 1);
      rs_en = 1'b0;
      tick();
      chk("valid0", result_valid, 0);
      chk("result_hold", result_ms, 7);

      // 5. saturation and late flag
      time_clr = 1'b1;
      tick();
      chk("clr_react", react_ms, 0);
      time_clr = 1'b0;
      time_en = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk("sat_react", react_ms, (k / 4 > 10) ? 10 : k / 4);
         chk("sat_late", time_late, (k >= 41) ? 1 : 0);
      end
      time_en = 1'b0;
      time_clr = 1'b1;
      tick();
      chk("clr2_react", react_ms, 0);
      chk("clr2_late", time_late, 0);
      time_clr = 1'b0;

      // 6. fixed wait, then reset in the middle of one
      start_wait5 = 1'b1;
      tick();
      chk("w5_rise", wait5_done, 0);
      wait_done(1'b1, 20, "w5_expiry");
      start_wait5 = 1'b0;
      tick();
      chk("w5_drop", wait5_done, 0);
      start_wait5 = 1'b1;
      repeat (10) tick();
      RESET = 1'b1;
      start_wait5 = 1'b0;
      tick();
      chk("w5_rst", wait5_done, 0);
      chk("w5_rst_rlen", rwait_len_ms, 0);
      tick();
      RESET = 1'b0;
      begin
         int seen = 0;
         repeat (30) begin
            tick();
            if (wait5_done) seen++;
         end
         chk("w5_after_rst", seen, 0);
      end
      start_rwait = 1'b1;
      exp_len = 14'd2 + 14'(m_lfsr & 16'd3);
      tick();
      chk("reseed_len", rwait_len_ms, exp_len);
      start_rwait = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
